// File: rtl/window3x3_gen.sv
// -----------------------------------------------------------------------------
// window3x3_gen
//   Raster-scan pixel stream to 3x3 sliding-window generator. Buffers the two
//   previous image lines and emits one window per accepted pixel once three
//   rows and three columns are available (no padding). A frame yields
//   (IMG_HEIGHT-2) x (IMG_WIDTH-2) windows.
//
// Parameters
//   DATA_WIDTH   pixel width, signed two's complement
//   IMG_WIDTH    pixels per line (>= 3)
//   IMG_HEIGHT   lines per frame (>= 3)
//
// Ports
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   valid_in     pixel_in valid this cycle (no backpressure)
//   sof_in       with valid_in: this pixel is frame position (0,0)
//   pixel_in     raster-order pixel
//   valid_out    window outputs valid this cycle
//   p00..p22     window, pRC = row R (0 = oldest), column C (0 = leftmost)
//   frame_done   one-cycle pulse with the last window of a frame
//   out_row/out_col  (only with WIN_COORD_EN) output window coordinate
//
// Build option
//   WIN_COORD_EN  when defined, adds out_row/out_col coordinate outputs.
// -----------------------------------------------------------------------------
module window3x3_gen #(
    parameter int DATA_WIDTH = 8,
    parameter int IMG_WIDTH  = 28,
    parameter int IMG_HEIGHT = 28,
    localparam int COL_W     = $clog2(IMG_WIDTH),
    localparam int ROW_W     = $clog2(IMG_HEIGHT)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         valid_in,
    input  logic                         sof_in,
    input  logic signed [DATA_WIDTH-1:0] pixel_in,
    output logic                         valid_out,
    output logic signed [DATA_WIDTH-1:0] p00,
    output logic signed [DATA_WIDTH-1:0] p01,
    output logic signed [DATA_WIDTH-1:0] p02,
    output logic signed [DATA_WIDTH-1:0] p10,
    output logic signed [DATA_WIDTH-1:0] p11,
    output logic signed [DATA_WIDTH-1:0] p12,
    output logic signed [DATA_WIDTH-1:0] p20,
    output logic signed [DATA_WIDTH-1:0] p21,
    output logic signed [DATA_WIDTH-1:0] p22,
`ifdef WIN_COORD_EN
    output logic        [ROW_W-1:0]      out_row,
    output logic        [COL_W-1:0]      out_col,
`endif
    output logic                         frame_done
);

    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_WIDTH - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_HEIGHT - 1);
    localparam logic [COL_W-1:0] COL_TWO  = COL_W'(2);
    localparam logic [ROW_W-1:0] ROW_TWO  = ROW_W'(2);

    logic [COL_W-1:0] col_q, col_d, pos_col;
    logic [ROW_W-1:0] row_q, row_d, pos_row;
    logic             win_ok, last_pix;
    logic             valid_out_q, frame_done_q;

    logic signed [DATA_WIDTH-1:0] lb0_q [IMG_WIDTH];
    logic signed [DATA_WIDTH-1:0] lb1_q [IMG_WIDTH];
    logic signed [DATA_WIDTH-1:0] lb0_rd, lb1_rd;
    logic signed [DATA_WIDTH-1:0] win_q [3][3];

    // Position of the pixel being accepted; sof_in forces (0,0) so a
    // misaligned stream realigns on the start-of-frame marker.
    always_comb begin
        pos_col  = sof_in ? '0 : col_q;
        pos_row  = sof_in ? '0 : row_q;
        lb0_rd   = lb0_q[pos_col];
        lb1_rd   = lb1_q[pos_col];
        win_ok   = (pos_row >= ROW_TWO) && (pos_col >= COL_TWO);
        // sof_in on the final pixel wins, so it cannot end a frame.
        last_pix = !sof_in && (row_q == ROW_LAST) && (col_q == COL_LAST);

        col_d = col_q;
        row_d = row_q;
        if (valid_in) begin
            if (pos_col == COL_LAST) begin
                col_d = '0;
                row_d = (pos_row == ROW_LAST) ? '0 : pos_row + 1'b1;
            end else begin
                col_d = pos_col + 1'b1;
                row_d = pos_row;
            end
        end
    end

    // Line buffers carry no reset: rows 0 and 1 overwrite every entry before
    // any window that reads them can be presented.
    always_ff @(posedge clk) begin
        if (valid_in) begin
            lb1_q[pos_col] <= lb0_rd;
            lb0_q[pos_col] <= pixel_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_q        <= '0;
            row_q        <= '0;
            valid_out_q  <= 1'b0;
            frame_done_q <= 1'b0;
            for (int r = 0; r < 3; r++) begin
                for (int c = 0; c < 3; c++) begin
                    win_q[r][c] <= '0;
                end
            end
        end else begin
            col_q        <= col_d;
            row_q        <= row_d;
            valid_out_q  <= valid_in && win_ok;
            frame_done_q <= valid_in && last_pix;
            if (valid_in) begin
                for (int r = 0; r < 3; r++) begin
                    win_q[r][0] <= win_q[r][1];
                    win_q[r][1] <= win_q[r][2];
                end
                win_q[0][2] <= lb1_rd;
                win_q[1][2] <= lb0_rd;
                win_q[2][2] <= pixel_in;
            end
        end
    end

`ifdef WIN_COORD_EN
    logic [ROW_W-1:0] out_row_q;
    logic [COL_W-1:0] out_col_q;

    // Coordinates only move when a window is produced, so they stay aligned
    // with the held window outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_row_q <= '0;
            out_col_q <= '0;
        end else if (valid_in && win_ok) begin
            out_row_q <= pos_row - ROW_TWO;
            out_col_q <= pos_col - COL_TWO;
        end
    end

    assign out_row = out_row_q;
    assign out_col = out_col_q;
`endif

    assign valid_out  = valid_out_q;
    assign frame_done = frame_done_q;
    assign p00 = win_q[0][0];
    assign p01 = win_q[0][1];
    assign p02 = win_q[0][2];
    assign p10 = win_q[1][0];
    assign p11 = win_q[1][1];
    assign p12 = win_q[1][2];
    assign p20 = win_q[2][0];
    assign p21 = win_q[2][1];
    assign p22 = win_q[2][2];

endmodule

// File: tb/tb_window3x3_gen.sv
// Directed bench for window3x3_gen on a 4x4 image of 8-bit pixels.
module tb_window3x3_gen;

    logic              clk;
    logic              rst_n;
    logic              valid_in;
    logic              sof_in;
    logic signed [7:0] pixel_in;
    logic              valid_out;
    logic              frame_done;
    logic signed [7:0] p00, p01, p02, p10, p11, p12, p20, p21, p22;
`ifdef WIN_COORD_EN
    logic [1:0] out_row;
    logic [1:0] out_col;
`endif
    logic [71:0] win_bus;

    int checks = 0;
    int errors = 0;

    window3x3_gen #(
        .DATA_WIDTH (8),
        .IMG_WIDTH  (4),
        .IMG_HEIGHT (4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .valid_in   (valid_in),
        .sof_in     (sof_in),
        .pixel_in   (pixel_in),
        .valid_out  (valid_out),
        .p00        (p00),
        .p01        (p01),
        .p02        (p02),
        .p10        (p10),
        .p11        (p11),
        .p12        (p12),
        .p20        (p20),
        .p21        (p21),
        .p22        (p22),
`ifdef WIN_COORD_EN
        .out_row    (out_row),
        .out_col    (out_col),
`endif
        .frame_done (frame_done)
    );

    assign win_bus = {p00, p01, p02, p10, p11, p12, p20, p21, p22};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Window whose top-left pixel is value tl in a 4-wide image of values
    // 1..16 (negated when neg is set).
    function automatic logic [71:0] mkwin(input int tl, input bit neg);
        logic [71:0] w;
        int          v;
        w = '0;
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
                v = tl + r * 4 + c;
                if (neg) v = -v;
                w = {w[63:0], 8'(v)};
            end
        end
        return w;
    endfunction

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chkw(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic send(input bit v, input bit sof, input logic [7:0] pix);
        valid_in = v;
        sof_in   = sof;
        pixel_in = pix;
        @(posedge clk);
        #1;
        valid_in = 1'b0;
        sof_in   = 1'b0;
    endtask

    // Accept pixel k (1..16) of a frame and check the registered outputs.
    task automatic frame_pix(input int k, input bit neg, input bit sof, input bit fd_ok);
        bit exp_v;
        send(1'b1, sof, neg ? 8'(-k) : 8'(k));
        exp_v = ((k - 1) / 4 >= 2) && ((k - 1) % 4 >= 2);
        chk1($sformatf("valid_out k=%0d", k), valid_out, exp_v);
        chk1($sformatf("frame_done k=%0d", k), frame_done, fd_ok && (k == 16));
        if (exp_v) begin
            chkw($sformatf("window k=%0d", k), win_bus, mkwin(k - 10, neg));
`ifdef WIN_COORD_EN
            chkw($sformatf("out_row k=%0d", k), 72'(out_row), 72'((k - 1) / 4 - 2));
            chkw($sformatf("out_col k=%0d", k), 72'(out_col), 72'((k - 1) % 4 - 2));
`endif
        end
    endtask

    task automatic full_frame(input bit neg, input bit sof_first);
        for (int k = 1; k <= 16; k++) begin
            frame_pix(k, neg, sof_first && (k == 1), 1'b1);
        end
    endtask

    logic [71:0] held;

    initial begin
        rst_n    = 1'b0;
        valid_in = 1'b0;
        sof_in   = 1'b0;
        pixel_in = '0;
        #12;
        chk1("reset valid_out", valid_out, 1'b0);
        chk1("reset frame_done", frame_done, 1'b0);
        chkw("reset window", win_bus, 72'h0);
        #5 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Continuous frame, sof on first pixel.
        full_frame(1'b0, 1'b1);

        // Same frame with an idle cycle after every pixel.
        for (int k = 1; k <= 16; k++) begin
            frame_pix(k, 1'b0, k == 1, 1'b1);
            held = win_bus;
            send(1'b0, 1'b0, 8'hAA);
            chk1($sformatf("gap valid_out k=%0d", k), valid_out, 1'b0);
            chk1($sformatf("gap frame_done k=%0d", k), frame_done, 1'b0);
            chkw($sformatf("gap hold k=%0d", k), win_bus, held);
        end

        // Back-to-back frames, second with negative pixels.
        full_frame(1'b0, 1'b1);
        full_frame(1'b1, 1'b1);

        // Abort after 6 pixels via sof, then a clean frame.
        for (int k = 1; k <= 6; k++) frame_pix(k, 1'b0, k == 1, 1'b0);
        full_frame(1'b0, 1'b1);

        // sof on what would be the last pixel: no frame_done, realigns.
        for (int k = 1; k <= 15; k++) frame_pix(k, 1'b0, k == 1, 1'b0);
        frame_pix(1, 1'b0, 1'b1, 1'b0);
        for (int k = 2; k <= 16; k++) frame_pix(k, 1'b0, 1'b0, 1'b1);

        // Asynchronous reset mid-frame, right after a window is presented.
        for (int k = 1; k <= 11; k++) frame_pix(k, 1'b0, k == 1, 1'b1);
        #3 rst_n = 1'b0;
        #1;
        chk1("async reset valid_out", valid_out, 1'b0);
        chk1("async reset frame_done", frame_done, 1'b0);
        chkw("async reset window", win_bus, 72'h0);
`ifdef WIN_COORD_EN
        chkw("async reset out_row", 72'(out_row), 72'h0);
        chkw("async reset out_col", 72'(out_col), 72'h0);
`endif
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
        full_frame(1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
